op_stack: RTL and testbench

//  Parametrised operand stack for the stack-machine datapath; successor to the basic push/pop stack.

---
 rtl/op_stack_pkg.sv | 18 +
 rtl/op_stack_if.sv | 32 +++
 rtl/op_stack_mem.sv | 43 ++++
 rtl/op_stack.sv | 147 ++++++++++++++
 tb/tb_op_stack.sv | 139 +++++++++++++
 5 files changed

// File: rtl/op_stack_pkg.sv
// Shared opcode encoding and sizing helper for the operand stack.
package op_stack_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
   localparam logic [OP_W-1:0] OP_PUSH = 3'd1;
   localparam logic [OP_W-1:0] OP_POP  = 3'd2;
   localparam logic [OP_W-1:0] OP_REPL = 3'd3;
   localparam logic [OP_W-1:0] OP_DUP  = 3'd4;
   localparam logic [OP_W-1:0] OP_SWAP = 3'd5;

   // Width of an occupancy counter that must reach DEPTH itself.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/op_stack_if.sv
// Decoder/ALU-facing bundle of the operand stack: op request in, stack view and status out.
interface op_stack_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   import op_stack_pkg::*;

   localparam int CW = cnt_w(DEPTH);

   logic [OP_W-1:0]  op_i;
   logic [WIDTH-1:0] data_i;
   logic             clr_err;
   logic [WIDTH-1:0] tos_o;
   logic [WIDTH-1:0] nos_o;
   logic [CW-1:0]    count_o;
   logic             empty_o;
   logic             full_o;
   logic             ovf_o;
   logic             unf_o;
   logic             err_o;

   modport master (
      output op_i, data_i, clr_err,
      input  tos_o, nos_o, count_o, empty_o, full_o, ovf_o, unf_o, err_o
   );

   modport slave (
      input  op_i, data_i, clr_err,
      output tos_o, nos_o, count_o, empty_o, full_o, ovf_o, unf_o, err_o
   );

endinterface

// File: rtl/op_stack_mem.sv
// DEPTH x WIDTH register file with two write ports and two combinational read ports.
module op_stack_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we0,
   input  logic [AW-1:0]    waddr0,
   input  logic [WIDTH-1:0] wdata0,
   input  logic             we1,
   input  logic [AW-1:0]    waddr1,
   input  logic [WIDTH-1:0] wdata1,
   input  logic [AW-1:0]    raddr0,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata0,
   output logic [WIDTH-1:0] rdata1
);

   logic [WIDTH-1:0] entry [DEPTH];

   // Contents are don't-care after reset, so entries carry no reset term.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] entry_reg;

         always_ff @(posedge clk) begin
            if (we1 && waddr1 == AW'(gi)) begin
               entry_reg <= wdata1;
            end else if (we0 && waddr0 == AW'(gi)) begin
               entry_reg <= wdata0;
            end
         end

         assign entry[gi] = entry_reg;
      end
   endgenerate

   assign rdata0 = entry[raddr0];
   assign rdata1 = entry[raddr1];

endmodule

// File: rtl/op_stack.sv
// Operand stack executing one NOP/PUSH/POP/REPL/DUP(/SWAP) per clock with overflow/underflow reporting.
// SWAP (opcode 101) is built only when OP_STACK_SWAP_EN is defined; otherwise 101 behaves as NOP.
module op_stack
   import op_stack_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   op_stack_if.slave bus
);

   localparam int CW = cnt_w(DEPTH);
   localparam int AW = $clog2(DEPTH);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] TWO      = CW'(2);

   logic [CW-1:0]    count_reg, count_next;
   logic             ovf_reg, ovf_next;
   logic             unf_reg, unf_next;
   logic             err_reg, err_next;

   logic [AW-1:0]    top_idx, nos_idx, push_idx;
   logic             we0, we1;
   logic [AW-1:0]    waddr0, waddr1;
   logic [WIDTH-1:0] wdata0, wdata1;
   logic [WIDTH-1:0] rd_top, rd_nos;
   logic             has_one, has_two, is_full;

   // Indices wrap harmlessly when count is 0 or DEPTH; the decode never uses them then.
   assign top_idx  = AW'(count_reg - ONE);
   assign nos_idx  = AW'(count_reg - TWO);
   assign push_idx = AW'(count_reg);

   assign has_one = (count_reg != '0);
   assign has_two = (count_reg >= TWO);
   assign is_full = (count_reg == FULL_CNT);

   op_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (waddr0),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (waddr1),
      .wdata1 (wdata1),
      .raddr0 (top_idx),
      .raddr1 (nos_idx),
      .rdata0 (rd_top),
      .rdata1 (rd_nos)
   );

   always_comb begin
      count_next = count_reg;
      ovf_next   = 1'b0;
      unf_next   = 1'b0;
      we0        = 1'b0;
      we1        = 1'b0;
      waddr0     = push_idx;
      waddr1     = nos_idx;
      wdata0     = bus.data_i;
      wdata1     = rd_top;

      case (bus.op_i)
         OP_PUSH: begin
            if (is_full) begin
               ovf_next = 1'b1;
            end else begin
               we0        = 1'b1;
               count_next = count_reg + ONE;
            end
         end
         OP_POP: begin
            if (has_one) count_next = count_reg - ONE;
            else         unf_next   = 1'b1;
         end
         OP_REPL: begin
            if (has_one) begin
               we0    = 1'b1;
               waddr0 = top_idx;
            end else begin
               unf_next = 1'b1;
            end
         end
         OP_DUP: begin
            if (!has_one) begin
               unf_next = 1'b1;
            end else if (is_full) begin
               ovf_next = 1'b1;
            end else begin
               we0        = 1'b1;
               wdata0     = rd_top;
               count_next = count_reg + ONE;
            end
         end
`ifdef OP_STACK_SWAP_EN
         OP_SWAP: begin
            if (has_two) begin
               we0    = 1'b1;
               waddr0 = top_idx;
               wdata0 = rd_nos;
               we1    = 1'b1;
            end else begin
               unf_next = 1'b1;
            end
         end
`endif
         default: ;
      endcase

      // A fresh error outranks a simultaneous clear request.
      if (ovf_next || unf_next) err_next = 1'b1;
      else if (bus.clr_err)     err_next = 1'b0;
      else                      err_next = err_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
         err_reg   <= err_next;
      end
   end

   assign bus.tos_o   = has_one ? rd_top : '0;
   assign bus.nos_o   = has_two ? rd_nos : '0;
   assign bus.count_o = count_reg;
   assign bus.empty_o = !has_one;
   assign bus.full_o  = is_full;
   assign bus.ovf_o   = ovf_reg;
   assign bus.unf_o   = unf_reg;
   assign bus.err_o   = err_reg;

endmodule

// File: tb/tb_op_stack.sv
// Directed bench for op_stack (WIDTH=8, DEPTH=4): driver queues hand-computed results, monitor compares.
module tb_op_stack;
   import op_stack_pkg::*;

   typedef struct {
      string      name;
      logic [2:0] cnt;
      logic [7:0] tos;
      logic [7:0] nos;
      logic       ovf;
      logic       unf;
      logic       err;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   checks;
   int   errors;
   bit   done;

   op_stack_if #(.WIDTH(8), .DEPTH(4)) bus();

   op_stack #(.WIDTH(8), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s.%s: got %0h, want %0h", nm, fld, act, want);
      end
   endtask

   // Monitor: every cycle with a pending expectation, compare the full visible state.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn %-12s count=%0d tos=%02h nos=%02h empty=%0b full=%0b ovf=%0b unf=%0b err=%0b",
                     e.name, bus.count_o, bus.tos_o, bus.nos_o, bus.empty_o, bus.full_o,
                     bus.ovf_o, bus.unf_o, bus.err_o);
            chk(e.name, "count", 32'(bus.count_o), 32'(e.cnt));
            chk(e.name, "tos",   32'(bus.tos_o),   32'(e.tos));
            chk(e.name, "nos",   32'(bus.nos_o),   32'(e.nos));
            chk(e.name, "empty", 32'(bus.empty_o), 32'(e.cnt == 3'd0));
            chk(e.name, "full",  32'(bus.full_o),  32'(e.cnt == 3'd4));
            chk(e.name, "ovf",   32'(bus.ovf_o),   32'(e.ovf));
            chk(e.name, "unf",   32'(bus.unf_o),   32'(e.unf));
            chk(e.name, "err",   32'(bus.err_o),   32'(e.err));
         end
      end
   end

   task automatic step(input string nm, input logic r, input logic [2:0] op, input logic [7:0] d,
                       input logic clr, input logic [2:0] c, input logic [7:0] t, input logic [7:0] n,
                       input logic o, input logic u, input logic e);
      exp_t x;
      @(negedge clk);
      rst         = r;
      bus.op_i    = op;
      bus.data_i  = d;
      bus.clr_err = clr;
      @(posedge clk);
      #1;
      x.name = nm; x.cnt = c; x.tos = t; x.nos = n; x.ovf = o; x.unf = u; x.err = e;
      exp_q.push_back(x);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      done        = 1'b0;
      rst         = 1'b1;
      bus.op_i    = OP_NOP;
      bus.data_i  = 8'h00;
      bus.clr_err = 1'b0;

      //    name           rst  op       data   clr  cnt tos    nos    ovf unf err
      step("reset",        1, OP_NOP,  8'h00, 0,   0, 8'h00, 8'h00, 0, 0, 0);
      step("push_aa",      0, OP_PUSH, 8'hAA, 0,   1, 8'hAA, 8'h00, 0, 0, 0);
      step("push_bb",      0, OP_PUSH, 8'hBB, 0,   2, 8'hBB, 8'hAA, 0, 0, 0);
      step("push_cc",      0, OP_PUSH, 8'hCC, 0,   3, 8'hCC, 8'hBB, 0, 0, 0);
      step("push_dd",      0, OP_PUSH, 8'hDD, 0,   4, 8'hDD, 8'hCC, 0, 0, 0);
      step("push_ovf",     0, OP_PUSH, 8'hEE, 0,   4, 8'hDD, 8'hCC, 1, 0, 1);
      step("repl_full",    0, OP_REPL, 8'h11, 0,   4, 8'h11, 8'hCC, 0, 0, 1);
      step("pop1",         0, OP_POP,  8'h00, 0,   3, 8'hCC, 8'hBB, 0, 0, 1);
      step("pop2",         0, OP_POP,  8'h00, 0,   2, 8'hBB, 8'hAA, 0, 0, 1);
      step("pop3",         0, OP_POP,  8'h00, 0,   1, 8'hAA, 8'h00, 0, 0, 1);
      step("pop4",         0, OP_POP,  8'h00, 0,   0, 8'h00, 8'h00, 0, 0, 1);
      step("pop_unf",      0, OP_POP,  8'h00, 0,   0, 8'h00, 8'h00, 0, 1, 1);
      step("dup_unf",      0, OP_DUP,  8'h00, 0,   0, 8'h00, 8'h00, 0, 1, 1);
      step("clr_err",      0, OP_NOP,  8'h00, 1,   0, 8'h00, 8'h00, 0, 0, 0);
      step("push_5a",      0, OP_PUSH, 8'h5A, 0,   1, 8'h5A, 8'h00, 0, 0, 0);
      step("dup1",         0, OP_DUP,  8'h00, 0,   2, 8'h5A, 8'h5A, 0, 0, 0);
      step("dup2",         0, OP_DUP,  8'h00, 0,   3, 8'h5A, 8'h5A, 0, 0, 0);
      step("dup3",         0, OP_DUP,  8'h00, 0,   4, 8'h5A, 8'h5A, 0, 0, 0);
      step("dup_ovf",      0, OP_DUP,  8'h00, 0,   4, 8'h5A, 8'h5A, 1, 0, 1);
      step("clr_vs_ovf",   0, OP_PUSH, 8'hEE, 1,   4, 8'h5A, 8'h5A, 1, 0, 1);
      step("clr_err2",     0, OP_NOP,  8'h00, 1,   4, 8'h5A, 8'h5A, 0, 0, 0);
      step("reserved7",    0, 3'd7,    8'h12, 0,   4, 8'h5A, 8'h5A, 0, 0, 0);
      step("reset2",       1, OP_NOP,  8'h00, 0,   0, 8'h00, 8'h00, 0, 0, 0);
      step("push_01",      0, OP_PUSH, 8'h01, 0,   1, 8'h01, 8'h00, 0, 0, 0);
      step("push_02",      0, OP_PUSH, 8'h02, 0,   2, 8'h02, 8'h01, 0, 0, 0);
`ifdef OP_STACK_SWAP_EN
      step("swap2",        0, OP_SWAP, 8'h00, 0,   2, 8'h01, 8'h02, 0, 0, 0);
      step("pop_swp",      0, OP_POP,  8'h00, 0,   1, 8'h02, 8'h00, 0, 0, 0);
      step("swap_unf",     0, OP_SWAP, 8'h00, 0,   1, 8'h02, 8'h00, 0, 1, 1);
      step("push_03",      0, OP_PUSH, 8'h03, 0,   2, 8'h03, 8'h02, 0, 0, 1);
`else
      step("swap_nop",     0, OP_SWAP, 8'h00, 0,   2, 8'h02, 8'h01, 0, 0, 0);
      step("pop_swp",      0, OP_POP,  8'h00, 0,   1, 8'h01, 8'h00, 0, 0, 0);
      step("swap_nop1",    0, OP_SWAP, 8'h00, 0,   1, 8'h01, 8'h00, 0, 0, 0);
      step("push_03",      0, OP_PUSH, 8'h03, 0,   2, 8'h03, 8'h01, 0, 0, 0);
`endif
      step("rst_vs_push",  1, OP_PUSH, 8'h77, 1,   0, 8'h00, 8'h00, 0, 0, 0);
      step("repl_unf",     0, OP_REPL, 8'h44, 0,   0, 8'h00, 8'h00, 0, 1, 1);
      step("push_99",      0, OP_PUSH, 8'h99, 0,   1, 8'h99, 8'h00, 0, 0, 1);

      @(negedge clk);
      bus.op_i = OP_NOP;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
